// File: rtl/hamming74_serial_tx.sv
// Hamming(7,4) encoder with UART-style serial transmitter (start, 7 code bits LSB first, stop).
// Latency: codeword registered on accept; first start-bit cycle follows; frame is 9*CLKS_PER_BIT cycles.
// Backpressure: ready_o only in IDLE; valid_i ignored while busy. Build option HAM_ERR_INJECT_EN adds err_pos_i.
module hamming74_serial_tx #(
  parameter int CLKS_PER_BIT = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] data_i,
  input  logic       valid_i,
`ifdef HAM_ERR_INJECT_EN
  input  logic [2:0] err_pos_i,
`endif
  output logic       ready_o,
  output logic [6:0] code_o,
  output logic       tx_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [6:0]    code_q, code_d;
  logic          tx_q, tx_d;
  logic          done_q, done_d;

  logic [6:0]    enc;
  logic [6:0]    err_mask;
  logic          accept;
  logic          bit_end;

  // Hamming(7,4) encoder: code position k lives in enc[k-1]
  always_comb begin
    enc[0] = data_i[0] ^ data_i[1] ^ data_i[3];
    enc[1] = data_i[0] ^ data_i[2] ^ data_i[3];
    enc[2] = data_i[0];
    enc[3] = data_i[1] ^ data_i[2] ^ data_i[3];
    enc[4] = data_i[1];
    enc[5] = data_i[2];
    enc[6] = data_i[3];
  end

`ifdef HAM_ERR_INJECT_EN
  // Single-bit error injection at code position err_pos_i (0 = clean)
  always_comb begin
    err_mask = 7'd0;
    if (err_pos_i != 3'd0) begin
      err_mask = 7'd1 << (err_pos_i - 3'd1);
    end
  end
`else
  assign err_mask = 7'd0;
`endif

  assign accept  = valid_i && (state_q == S_IDLE);
  assign bit_end = (cnt_q == CNT_LAST);

  // Next-state logic: baud counter, bit index, codeword capture, done pulse
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    code_d  = code_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = 3'd0;
        if (accept) begin
          code_d  = enc ^ err_mask;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          // Index parks at 6 on the last data bit rather than wrapping
          if (idx_q == 3'd6) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = 3'd0;
      end
    endcase
  end

  // Line level registered from the next state so tx_o is glitch-free and aligned with state
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = code_d[idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  // State register; reset aborts any frame in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      code_q  <= 7'd0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign ready_o = (state_q == S_IDLE);
  assign busy_o  = (state_q != S_IDLE);
  assign code_o  = code_q;
  assign tx_o    = tx_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_hamming74_serial_tx.sv
// Self-checking bench for hamming74_serial_tx: vector table, hand-written corner sequences,
// and random nibbles against a position-based Hamming reference model.
// Every DUT output is sampled 1 time unit after the rising edge.
module tb_hamming74_serial_tx;

  localparam int C = 4;

  logic       clk;
  logic       rst;
  logic [3:0] data_i;
  logic       valid_i;
  logic [2:0] err_pos;
  logic       ready_o;
  logic [6:0] code_o;
  logic       tx_o;
  logic       busy_o;
  logic       done_o;

  int n_cmp;
  int n_bad;

  hamming74_serial_tx #(.CLKS_PER_BIT(C)) dut (
`ifdef HAM_ERR_INJECT_EN
    .err_pos_i (err_pos),
`endif
    .clk       (clk),
    .rst       (rst),
    .data_i    (data_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .code_o    (code_o),
    .tx_o      (tx_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the whole run is a few thousand cycles
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder: parity at power-of-two positions covers every position sharing that bit
  function automatic logic [6:0] ham_ref(input logic [3:0] d, input logic [2:0] e);
    logic [7:0] c;
    int di;
    c  = 8'd0;
    di = 0;
    for (int k = 1; k <= 7; k++) begin
      if ((k & (k - 1)) != 0) begin
        c[k] = d[di];
        di++;
      end
    end
    for (int p = 1; p <= 4; p = p * 2) begin
      for (int k = 1; k <= 7; k++) begin
        if (k != p && (k & p) != 0) c[p] = c[p] ^ c[k];
      end
    end
    if (e != 3'd0) c[e] = ~c[e];
    return c[7:1];
  endfunction

  // Reference decoder: syndrome is the XOR of positions holding a 1
  function automatic logic [3:0] ham_dec(input logic [6:0] cw);
    logic [7:0] c;
    int syn;
    c   = {cw, 1'b0};
    syn = 0;
    for (int k = 1; k <= 7; k++) if (c[k]) syn = syn ^ k;
    if (syn != 0) c[syn] = ~c[syn];
    return {c[7], c[6], c[5], c[3]};
  endfunction

  // Drive one nibble; returns just after the accepting edge (first START cycle)
  task automatic do_accept(input logic [3:0] d, input logic [2:0] e, input bit hold);
    data_i  = d;
    err_pos = e;
    valid_i = 1'b1;
    tick();
    if (!hold) valid_i = 1'b0;
    chk("busy_after_accept", 32'(busy_o), 32'(1));
    chk("ready_after_accept", 32'(ready_o), 32'(0));
  endtask

  // Checks every line cycle of one frame; returns in the done_o cycle
  task automatic frame_check(input logic [6:0] exp_code);
    logic b;
    chk("code_o", 32'(code_o), 32'(exp_code));
    for (int c = 0; c < 9 * C; c++) begin
      if (c < C)          b = 1'b0;
      else if (c < 8 * C) b = exp_code[c / C - 1];
      else                b = 1'b1;
      chk("tx_bit", 32'(tx_o), 32'(b));
      chk("done_low_in_frame", 32'(done_o), 32'(0));
      chk("busy_in_frame", 32'(busy_o), 32'(1));
      tick();
    end
    chk("done_pulse", 32'(done_o), 32'(1));
    chk("ready_at_done", 32'(ready_o), 32'(1));
    chk("busy_at_done", 32'(busy_o), 32'(0));
    chk("tx_idle_at_done", 32'(tx_o), 32'(1));
    chk("code_hold", 32'(code_o), 32'(exp_code));
  endtask

  typedef struct {
    logic [3:0] d;
    logic [6:0] code;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [3:0] rd;
    logic [2:0] re;
    logic [6:0] rexp;
    int gap;

    n_cmp = 0;
    n_bad = 0;
    vecs[0] = '{d: 4'b0001, code: 7'b0000111};
    vecs[1] = '{d: 4'b1011, code: 7'b1010101};
    vecs[2] = '{d: 4'b1111, code: 7'b1111111};
    vecs[3] = '{d: 4'b0000, code: 7'b0000000};

    rst = 1'b1; valid_i = 1'b0; data_i = 4'd0; err_pos = 3'd0;
    tick();
    tick();
    chk("rst_tx", 32'(tx_o), 32'(1));
    chk("rst_ready", 32'(ready_o), 32'(1));
    chk("rst_busy", 32'(busy_o), 32'(0));
    chk("rst_done", 32'(done_o), 32'(0));
    chk("rst_code", 32'(code_o), 32'(0));
    rst = 1'b0;
    tick();

    // Vector table: encoding, serial order and done timing
    for (int i = 0; i < 4; i++) begin
      do_accept(vecs[i].d, 3'd0, 1'b0);
      frame_check(vecs[i].code);
      tick();
      chk("done_one_cycle", 32'(done_o), 32'(0));
      chk("ready_idle", 32'(ready_o), 32'(1));
    end

    // Back-to-back with valid_i held: second accept lands in the done cycle
    do_accept(4'b0001, 3'd0, 1'b1);
    data_i = 4'b1111;
    frame_check(7'b0000111);
    tick();
    valid_i = 1'b0;
    chk("b2b_busy", 32'(busy_o), 32'(1));
    frame_check(7'b1111111);
    tick();

    // Reset during data bit 3: abort, no done pulse afterwards
    do_accept(4'b1011, 3'd0, 1'b0);
    for (int i = 0; i < 4 * C; i++) tick();
    chk("mid_tx_bit3", 32'(tx_o), 32'(1'b0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_tx", 32'(tx_o), 32'(1));
    chk("abort_ready", 32'(ready_o), 32'(1));
    chk("abort_busy", 32'(busy_o), 32'(0));
    chk("abort_done", 32'(done_o), 32'(0));
    chk("abort_code", 32'(code_o), 32'(0));
    for (int i = 0; i < 10 * C; i++) begin
      tick();
      chk("abort_no_done", 32'(done_o), 32'(0));
      chk("abort_line_high", 32'(tx_o), 32'(1));
    end

    // Reset and valid in the same cycle: nothing accepted
    rst = 1'b1; valid_i = 1'b1; data_i = 4'b1111;
    tick();
    rst = 1'b0; valid_i = 1'b0;
    chk("rstvalid_ready", 32'(ready_o), 32'(1));
    chk("rstvalid_code", 32'(code_o), 32'(0));
    tick();
    chk("rstvalid_still_idle", 32'(busy_o), 32'(0));

`ifdef HAM_ERR_INJECT_EN
    // Injected single-bit error at position 5, corrected by the reference decoder
    do_accept(4'b0001, 3'd5, 1'b0);
    frame_check(7'b0010111);
    chk("inject_decoded", 32'(ham_dec(code_o)), 32'(4'b0001));
    tick();
`endif

    // Random nibbles with random idle gaps
    for (int i = 0; i < 24; i++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) tick();
      rd = 4'($urandom);
`ifdef HAM_ERR_INJECT_EN
      re = 3'($urandom_range(0, 7));
`else
      re = 3'd0;
`endif
      rexp = ham_ref(rd, re);
      do_accept(rd, re, 1'b0);
      frame_check(rexp);
      chk("rand_decoded", 32'(ham_dec(code_o)), 32'(rd));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
